axi4_lite_slave_regfile: RTL

//  AXI4-Lite slave register file; directly consumes the m_axi_* bus produced by the AXI4-Lite master controller.

---
 rtl/axi4_lite_slave_regfile.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave register file with parallel register image
// Optional feature macro: AXI_REGFILE_WR_PULSE_EN (adds per-register write-commit pulse output)
module axi4_lite_slave_regfile #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
`ifdef AXI_REGFILE_WR_PULSE_EN
    output logic [32*NUM_REGS-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      wr_pulse
`else
    output logic [32*NUM_REGS-1:0]   regs_out
`endif
);
    localparam int IDXW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [31:0]     regs [NUM_REGS];
    logic [IDXW-1:0] aw_idx_q;
    logic            aw_ok_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;

    logic aw_hs, w_hs, ar_hs;
    logic have_aw, have_w, commit;
    logic [IDXW-1:0] c_idx, ar_idx;
    logic            c_ok, ar_ok;
    logic [31:0]     c_data;
    logic [3:0]      c_strb;
    logic            unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Commit uses whichever of AW/W is arriving now, falling back to the latched copy.
    assign have_aw = aw_hs | (wr_state == WR_GOT_AW);
    assign have_w  = w_hs | (wr_state == WR_GOT_W);
    assign commit  = have_aw & have_w;
    assign c_idx   = aw_hs ? s_axi_awaddr[IDXW+1:2] : aw_idx_q;
    assign c_ok    = aw_hs ? (s_axi_awaddr[31:IDXW+2] == '0) : aw_ok_q;
    assign c_data  = w_hs ? s_axi_wdata : wdata_q;
    assign c_strb  = w_hs ? s_axi_wstrb : wstrb_q;
    assign ar_idx  = s_axi_araddr[IDXW+1:2];
    assign ar_ok   = (s_axi_araddr[31:IDXW+2] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (commit)     wr_next = WR_RESP;
                else if (aw_hs) wr_next = WR_GOT_AW;
                else if (w_hs)  wr_next = WR_GOT_W;
            end
            WR_GOT_AW: if (w_hs)         wr_next = WR_RESP;
            WR_GOT_W:  if (aw_hs)        wr_next = WR_RESP;
            WR_RESP:   if (s_axi_bready) wr_next = WR_IDLE;
            default:                     wr_next = WR_IDLE;
        endcase
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)        rd_next = RD_RESP;
            RD_RESP: if (s_axi_rready) rd_next = RD_IDLE;
            default:                   rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (wr_state == WR_IDLE) || (wr_state == WR_GOT_W);
        s_axi_wready  = (wr_state == WR_IDLE) || (wr_state == WR_GOT_AW);
        s_axi_bvalid  = (wr_state == WR_RESP);
        s_axi_arready = (rd_state == RD_IDLE);
        s_axi_rvalid  = (rd_state == RD_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_idx_q    <= '0;
            aw_ok_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= 2'b00;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else begin
            if (aw_hs) begin
                aw_idx_q <= s_axi_awaddr[IDXW+1:2];
                aw_ok_q  <= (s_axi_awaddr[31:IDXW+2] == '0);
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) begin
                s_axi_bresp <= c_ok ? 2'b00 : 2'b10;
                if (c_ok) begin
                    for (int b = 0; b < 4; b++)
                        if (c_strb[b]) regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled from the pre-edge register image, so a same-edge write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rdata <= ar_ok ? regs[ar_idx] : 32'h0;
            s_axi_rresp <= ar_ok ? 2'b00 : 2'b10;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rdata <= '0;
        end
    end

`ifdef AXI_REGFILE_WR_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst)
            wr_pulse <= '0;
        else if (commit && c_ok)
            wr_pulse <= {{(NUM_REGS-1){1'b0}}, 1'b1} << c_idx;
        else
            wr_pulse <= '0;
    end
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[32*k +: 32] = regs[k];
    end
endmodule
